// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer
//   Host-side driver for a multiplier's start/done handshake. For each of num_jobs jobs it reads an
//   operand pair from operand memory, presents it on mul_a/mul_b, pulses mul_start, waits for
//   mul_done and writes the product to result memory at the job index. all_done pulses once the
//   batch is complete.
//
//   Optional feature macro: MJS_TIMEOUT_EN. When defined, a done-wait limit of TIMEOUT_CYCLES
//   aborts the batch and sets the sticky timeout_err output.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   go, num_jobs        host batch request (pulse) and job count, sampled in S_IDLE only
//   rd_en, rd_addr      operand memory read strobe/address
//   rd_data_a/b         operand read data, valid one cycle after rd_en
//   mul_a, mul_b        operands to the multiplier, stable from S_LATCH until mul_done
//   mul_start           one-cycle start pulse to the multiplier
//   mul_done/result     one-cycle done pulse and product from the multiplier
//   wr_en, wr_addr      result memory write strobe/address (address = job index)
//   wr_data             registered product
//   busy, all_done      batch in progress / one-cycle completion pulse
//   job_count           results written in the current batch
//   timeout_err         sticky done-wait timeout flag (MJS_TIMEOUT_EN only)

module mult_job_sequencer #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned RES_W          = 32,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W:0]   num_jobs,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [RES_W-1:0]  mul_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [RES_W-1:0]  wr_data,
    output logic              busy,
    output logic              all_done,
`ifdef MJS_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic [ADDR_W:0]   job_count
);

    typedef enum logic [7:0] {
        S_IDLE     = 8'b0000_0001,
        S_FETCH    = 8'b0000_0010,
        S_WAIT     = 8'b0000_0100,
        S_LATCH    = 8'b0000_1000,
        S_START_HI = 8'b0001_0000,
        S_START_LO = 8'b0010_0000,
        S_WRITE    = 8'b0100_0000,
        S_FINISH   = 8'b1000_0000
    } state_t;

    localparam logic [ADDR_W:0] ONE = 1;

    state_t          state;
    // Index and latched count are ADDR_W+1 bits so a full 2^ADDR_W batch ends without wrapping.
    logic [ADDR_W:0] index;
    logic [ADDR_W:0] n_jobs;
    logic [ADDR_W:0] index_next;
    logic [ADDR_W:0] last_index;

`ifdef MJS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`endif

    assign index_next = index + ONE;
    assign last_index = n_jobs - ONE;

    // Moore strobes (rd_en, mul_start, wr_en, all_done) are registered together with the state
    // they belong to, so each is high exactly for the one cycle spent in that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            index     <= '0;
            n_jobs    <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            all_done  <= 1'b0;
            job_count <= '0;
`ifdef MJS_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            rd_en     <= 1'b0;
            mul_start <= 1'b0;
            wr_en     <= 1'b0;
            all_done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        n_jobs    <= num_jobs;
                        job_count <= '0;
                        index     <= '0;
                        busy      <= 1'b1;
                        if (num_jobs == '0) begin
                            state    <= S_FINISH;
                            all_done <= 1'b1;
                        end else begin
                            state   <= S_FETCH;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    mul_a     <= rd_data_a;
                    mul_b     <= rd_data_b;
                    state     <= S_START_HI;
                    mul_start <= 1'b1;
                end
                S_START_HI: begin
                    // The multiplier cannot finish while start is high, so mul_done is not looked at.
                    state <= S_START_LO;
`ifdef MJS_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_START_LO: begin
                    if (mul_done) begin
                        wr_data <= mul_result;
                        wr_addr <= index[ADDR_W-1:0];
                        wr_en   <= 1'b1;
                        state   <= S_WRITE;
`ifdef MJS_TIMEOUT_EN
                    end else if (wait_cnt == TO_LAST) begin
                        // Abort the batch: no write for this job, but still report completion.
                        timeout_err <= 1'b1;
                        all_done    <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                S_WRITE: begin
                    job_count <= job_count + ONE;
                    if (index == last_index) begin
                        state    <= S_FINISH;
                        all_done <= 1'b1;
                    end else begin
                        index   <= index_next;
                        rd_addr <= index_next[ADDR_W-1:0];
                        rd_en   <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
